// File: rtl/mcu_pkg.sv
// Shared types and constants for the 8-bit multi-cycle microcontroller.
package mcu_pkg;

  localparam int DATA_W       = 8;
  localparam int TWO_BYTE_BIT = 7;

  typedef enum logic [1:0] {
    S_OP,
    S_ARG,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/prog_counter.sv
// Program counter register: async active-low reset to RESET_PC, load beats increment.
module prog_counter #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [DATA_W-1:0] load_addr,
  output logic [DATA_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + DATA_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: reads one- or two-byte instructions over req/ack and hands them downstream via valid/ready.
module fetch_unit #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] ir_op,
  output logic [DATA_W-1:0] ir_operand,
  output logic [DATA_W-1:0] pc,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_load_addr
);

  import mcu_pkg::*;

  fetch_state_t state;
  logic         req_q;
  logic         valid_q;
  logic         ack;
  logic         accept;
  logic         pc_inc;
  logic         pc_ld;

  // An ack is only honoured while a request is actually outstanding.
  assign ack    = mem_ack & req_q;
  assign accept = valid_q & instr_ready;
  assign pc_inc = ack;
  assign pc_ld  = accept & pc_load;

  assign mem_req     = req_q;
  assign mem_addr    = req_q ? pc : '0;
  assign instr_valid = valid_q;

  prog_counter #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (pc_inc),
    .load      (pc_ld),
    .load_addr (pc_load_addr),
    .pc        (pc)
  );

  // req_q/valid_q are registered copies of the next-state decode, so the
  // request only appears one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OP;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      ir_op      <= '0;
      ir_operand <= '0;
    end else begin
      case (state)
        S_OP: begin
          req_q <= 1'b1;
          if (ack) begin
            ir_op      <= mem_rdata;
            ir_operand <= '0;
            if (mem_rdata[TWO_BYTE_BIT]) begin
              state <= S_ARG;
            end else begin
              state   <= S_HOLD;
              req_q   <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        S_ARG: begin
          if (ack) begin
            ir_operand <= mem_rdata;
            state      <= S_HOLD;
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
          end
        end
        S_HOLD: begin
          if (accept) begin
            state   <= S_OP;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= S_OP;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a wait-state memory model and an accept-side scoreboard.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] ir_op;
  logic [7:0] ir_operand;
  logic [7:0] pc;
  logic       pc_load = 1'b0;
  logic [7:0] pc_load_addr = '0;

  logic [7:0]  mem [256];
  int unsigned waits = 0;
  int unsigned wcnt = 0;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] sb [$];

  fetch_unit #(
    .DATA_W   (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .ir_op        (ir_op),
    .ir_operand   (ir_operand),
    .pc           (pc),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acks after `waits` idle cycles of a steady request.
  always @(negedge clk) begin
    if (!rst_n || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= waits) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      wcnt      = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  // Monitor: every instruction the DUT hands over must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got op=%0h opnd=%0h pc=%0h expected nothing", ir_op, ir_operand, pc);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        check("sb_op", {24'd0, ir_op}, {24'd0, e[23:16]});
        check("sb_operand", {24'd0, ir_operand}, {24'd0, e[15:8]});
        check("sb_pc", {24'd0, pc}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc);
    int c;
    c = 0;
    while (!instr_valid && c < maxc) begin
      step();
      c++;
    end
    check("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic hold_check(input string tag, input logic [7:0] op, input logic [7:0] opnd, input logic [7:0] p);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_op"}, {24'd0, ir_op}, {24'd0, op});
    check({tag, "_operand"}, {24'd0, ir_operand}, {24'd0, opnd});
    check({tag, "_pc"}, {24'd0, pc}, {24'd0, p});
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    step();
    step();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_op", {24'd0, ir_op}, 32'd0);
    check("rst_operand", {24'd0, ir_operand}, 32'd0);

    // One-byte instruction, zero-wait memory
    mem[0] = 8'h12;
    waits  = 0;
    rst_n  = 1'b1;
    #1;
    check("t1_req_at_release", {31'd0, mem_req}, 32'd0);
    step();
    check("t1_req_rise", {31'd0, mem_req}, 32'd1);
    check("t1_addr", {24'd0, mem_addr}, 32'd0);
    check("t1_valid_low", {31'd0, instr_valid}, 32'd0);
    step();
    hold_check("t1", 8'h12, 8'h00, 8'h01);
    sb.push_back({8'h12, 8'h00, 8'h01});
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t1_next_req", {31'd0, mem_req}, 32'd1);
    check("t1_next_addr", {24'd0, mem_addr}, 32'd1);

    // Two-byte instruction with two wait cycles per read
    mem[0] = 8'h85;
    mem[1] = 8'h3C;
    waits  = 2;
    do_reset();
    step();
    for (int i = 0; i < 6; i++) begin
      check("t2_req", {31'd0, mem_req}, 32'd1);
      check("t2_addr", {24'd0, mem_addr}, (i < 3) ? 32'd0 : 32'd1);
      check("t2_valid_low", {31'd0, instr_valid}, 32'd0);
      step();
    end
    hold_check("t2", 8'h85, 8'h3C, 8'h02);
    sb.push_back({8'h85, 8'h3C, 8'h02});

    // Downstream stall
    for (int i = 0; i < 5; i++) begin
      step();
      hold_check("t3_stall", 8'h85, 8'h3C, 8'h02);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t3_req_after_accept", {31'd0, mem_req}, 32'd1);
    check("t3_addr_after_accept", {24'd0, mem_addr}, 32'd2);
    check("t3_valid_after_accept", {31'd0, instr_valid}, 32'd0);

    // pc_load ignored in S_ARG, honoured on the accept edge
    mem[2]   = 8'h81;
    mem[3]   = 8'h07;
    mem[8'hA0] = 8'h01;
    waits    = 0;
    step();
    check("t4_arg_addr", {24'd0, mem_addr}, 32'd3);
    pc_load      = 1'b1;
    pc_load_addr = 8'hA0;
    step();
    hold_check("t4", 8'h81, 8'h07, 8'h04);
    sb.push_back({8'h81, 8'h07, 8'h04});
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    check("t4_branch_req", {31'd0, mem_req}, 32'd1);
    check("t4_branch_addr", {24'd0, mem_addr}, 32'hA0);
    step();
    hold_check("t4b", 8'h01, 8'h00, 8'hA1);
    sb.push_back({8'h01, 8'h00, 8'hA1});

    // Branch to 0xFF, two-byte instruction wrapping to 0x00
    mem[8'hFF] = 8'h90;
    mem[0]     = 8'h55;
    instr_ready  = 1'b1;
    pc_load      = 1'b1;
    pc_load_addr = 8'hFF;
    step();
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    check("t5_addr_ff", {24'd0, mem_addr}, 32'hFF);
    step();
    check("t5_addr_wrap", {24'd0, mem_addr}, 32'h00);
    step();
    hold_check("t5", 8'h90, 8'h55, 8'h01);
    sb.push_back({8'h90, 8'h55, 8'h01});
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t5_next_addr", {24'd0, mem_addr}, 32'h01);

    // Asynchronous reset in S_ARG discards the partial instruction
    mem[1] = 8'hC0;
    step();
    check("t6_arg_req", {31'd0, mem_req}, 32'd1);
    check("t6_arg_addr", {24'd0, mem_addr}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_req", {31'd0, mem_req}, 32'd0);
    check("t6_async_addr", {24'd0, mem_addr}, 32'd0);
    check("t6_async_valid", {31'd0, instr_valid}, 32'd0);
    check("t6_async_pc", {24'd0, pc}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_restart_addr", {24'd0, mem_addr}, 32'd0);
    wait_valid(10);
    hold_check("t6", 8'h55, 8'h00, 8'h01);
    sb.push_back({8'h55, 8'h00, 8'h01});
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
